// File: rtl/riscy_pkg.sv
// Shared definitions for the RAM arbiter.
//   arb_state_t : arbiter FSM states
//   PORT_CPU    : requester index of the CPU phase generator
//   PORT_DMA    : requester index of the DMA/loader engine
//   port_oh()   : one-hot port vector for a port index
package riscy_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  function automatic logic [1:0] port_oh(input logic p);
    logic [1:0] oh;
    oh           = '0;
    oh[PORT_CPU] = ~p;
    oh[PORT_DMA] = p;
    return oh;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
//   Requester side : REQ, WE, ADDRx, WDATAx, LOCK in; GNT, ACK, RDATAx out
//   RAM side       : RAM_CS_, RAM_OE, RAM_WE, RAM_ADDR, RAM_WDATA out;
//                    RAM_RDATA in
//   slave  modport : arbiter view
//   master modport : requesters + RAM view
interface ram_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [1:0]        REQ;
  logic [1:0]        WE;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic [1:0]        LOCK;
  logic [1:0]        GNT;
  logic [1:0]        ACK;
  logic [DATA_W-1:0] RDATA0, RDATA1;
  logic              RAM_CS_;
  logic              RAM_OE;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;

  modport slave (
    input  REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, LOCK, RAM_RDATA,
    output GNT, ACK, RDATA0, RDATA1, RAM_CS_, RAM_OE, RAM_WE, RAM_ADDR, RAM_WDATA
  );

  modport master (
    output REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, LOCK, RAM_RDATA,
    input  GNT, ACK, RDATA0, RDATA1, RAM_CS_, RAM_OE, RAM_WE, RAM_ADDR, RAM_WDATA
  );
endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational 2-way round-robin picker.
//   REQ       : candidate requests
//   LAST      : port granted most recently
//   LOCK_HOLD : force a regrant of LAST (caller guarantees REQ[LAST])
//   WIN       : chosen port
//   VALID     : a port was chosen
module ram_arb_rr_pick (
  input  logic [1:0] REQ,
  input  logic       LAST,
  input  logic       LOCK_HOLD,
  output logic       WIN,
  output logic       VALID
);

  always_comb begin
    VALID = |REQ;
    WIN   = REQ[1];
    if (LOCK_HOLD) begin
      WIN   = LAST;
      VALID = 1'b1;
    end else if (&REQ) begin
      WIN = ~LAST;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between the CPU (port 0) and DMA (port 1).
// Each transaction runs SETUP -> ACCESS -> DONE with registered RAM strobes;
// ACK pulses in DONE and read data lands in RDATAx at the end of ACCESS.
//   CLK, RST_ : clock, asynchronous active-low reset
//   bus       : ram_arbiter_if.slave (requester handshake + RAM pins)
// Optional build macro RAM_ARB_LOCK_EN: a locked, still-requesting winner is
// regranted from DONE without touching the round-robin pointer.
module ram_arbiter
  import riscy_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic          CLK,
  input  logic          RST_,
  ram_arbiter_if.slave  bus
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t              state_q, state_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              ack_q, ack_d;
  logic                    last_q, last_d;
  logic                    win_q, win_d;
  req_t                    cap_q, cap_d;
  logic                    cs_n_q, cs_n_d;
  logic                    oe_q, oe_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

  req_t       req_in0, req_in1, sel;
  logic [1:0] pick_req;
  logic       pick_last, lock_hold, pick_win, pick_vld, launch;

  assign req_in0 = '{we: bus.WE[PORT_CPU], addr: bus.ADDR0, wdata: bus.WDATA0};
  assign req_in1 = '{we: bus.WE[PORT_DMA], addr: bus.ADDR1, wdata: bus.WDATA1};
  assign sel     = pick_win ? req_in1 : req_in0;

  // In DONE the port being acknowledged is masked out: its still-high REQ
  // only counts as a new request from the following cycle on.
  always_comb begin
    pick_last = last_q;
    pick_req  = bus.REQ;
    lock_hold = 1'b0;
    if (state_q == DONE) begin
      pick_last = win_q;
`ifdef RAM_ARB_LOCK_EN
      lock_hold = bus.LOCK[win_q] & bus.REQ[win_q];
`endif
      if (!lock_hold) pick_req = bus.REQ & ~port_oh(win_q);
    end
  end

`ifdef RAM_ARB_LOCK_EN
`else
  logic unused_lock;
  assign unused_lock = ^bus.LOCK;
`endif

  ram_arb_rr_pick u_pick (
    .REQ       (pick_req),
    .LAST      (pick_last),
    .LOCK_HOLD (lock_hold),
    .WIN       (pick_win),
    .VALID     (pick_vld)
  );

  // Strobe registers are loaded with the values the next state must show,
  // so every RAM pin is a flop output.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    last_d  = last_q;
    win_d   = win_q;
    cap_d   = cap_q;
    cs_n_d  = 1'b1;
    oe_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: launch = pick_vld;
      SETUP: begin
        state_d = ACCESS;
        cs_n_d  = 1'b0;
        oe_d    = ~cap_q.we;
        we_d    = cap_q.we;
        if (cap_q.we) wdata_d = cap_q.wdata;
      end
      ACCESS: begin
        state_d = DONE;
        ack_d   = port_oh(win_q);
        if (!cap_q.we) rdata_d[win_q] = bus.RAM_RDATA;
      end
      DONE: begin
        if (!lock_hold) last_d = win_q;
        state_d = IDLE;
        gnt_d   = '0;
        launch  = pick_vld;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = SETUP;
      win_d   = pick_win;
      cap_d   = sel;
      gnt_d   = port_oh(pick_win);
      cs_n_d  = 1'b0;
      addr_d  = sel.addr;
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      last_q  <= 1'b1;  // port 0 wins the first tie
      win_q   <= 1'b0;
      cap_q   <= '0;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cap_q   <= cap_d;
      cs_n_q  <= cs_n_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.ACK       = ack_q;
  assign bus.RDATA0    = rdata_q[PORT_CPU];
  assign bus.RDATA1    = rdata_q[PORT_DMA];
  assign bus.RAM_CS_   = cs_n_q;
  assign bus.RAM_OE    = oe_q;
  assign bus.RAM_WE    = we_q;
  assign bus.RAM_ADDR  = addr_q;
  assign bus.RAM_WDATA = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: reset values, a table of isolated
// transactions, directed multi-cycle sequences and a randomized run checked
// against a transaction-level model (shadow memory + round-robin rule).
module tb_ram_arbiter;

  logic CLK, RST_;
  ram_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .CLK  (CLK),
    .RST_ (RST_),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model
  logic [7:0] mem [32];
  logic       pre_en;
  logic [4:0] pre_addr;
  logic [7:0] pre_data;
  always @(posedge CLK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!bus.RAM_CS_ && bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
  end
  assign bus.RAM_RDATA = (bus.RAM_OE && !bus.RAM_CS_) ? mem[bus.RAM_ADDR] : 8'h00;

  int n_cmp, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic set_port(input bit p, input bit we, input logic [4:0] a, input logic [7:0] d);
    bus.WE[p] = we;
    if (p) begin bus.ADDR1 = a; bus.WDATA1 = d; end
    else   begin bus.ADDR0 = a; bus.WDATA0 = d; end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_ = 1'b0; bus.REQ = '0; bus.LOCK = '0;
    repeat (2) @(negedge CLK);
    RST_ = 1'b1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK); pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK); pre_en = 1'b0;
  endtask

  // One isolated transaction; cycle indices count negedges after REQ goes up.
  task automatic run_xact(input string tag, input bit p, input bit we,
                          input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int t_gnt, t_acc, t_ack, n_we, n_oe;
    logic [4:0] acc_a;
    logic [7:0] acc_d, rd;
    t_gnt = -1; t_acc = -1; t_ack = -1; n_we = 0; n_oe = 0;
    acc_a = 'x; acc_d = 'x; rd = 'x;
    @(negedge CLK);
    set_port(p, we, a, d);
    bus.REQ[p] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (t_gnt < 0 && bus.GNT[p]) t_gnt = c;
      if (bus.RAM_OE || bus.RAM_WE) begin
        if (t_acc < 0) t_acc = c;
        acc_a = bus.RAM_ADDR; acc_d = bus.RAM_WDATA;
      end
      if (bus.RAM_WE) n_we++;
      if (bus.RAM_OE) n_oe++;
      if (bus.ACK[p]) begin
        t_ack = c;
        rd = p ? bus.RDATA1 : bus.RDATA0;
        bus.REQ[p] = 1'b0;
        break;
      end
    end
    bus.REQ[p] = 1'b0;
    chk({tag, "_gnt_lat"}, t_gnt, 1);
    chk({tag, "_acc_lat"}, t_acc, 2);
    chk({tag, "_ack_lat"}, t_ack, 3);
    chk({tag, "_ram_addr"}, acc_a, a);
    chk({tag, "_we_cycles"}, n_we, we ? 1 : 0);
    chk({tag, "_oe_cycles"}, n_oe, we ? 0 : 1);
    if (we) chk({tag, "_ram_wdata"}, acc_d, d);
    else    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  // random-phase model state
  logic [7:0] sh [32];
  bit         out_v [2], out_we [2];
  logic [4:0] out_a [2];
  logic [7:0] out_d [2];
  int         out_t [2];
  logic [1:0] req_drv, gnt_prev, ack_prev, pend;
  bit         last_m, exp_w;

  initial begin
    n_cmp = 0; n_err = 0;
    RST_ = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.REQ = '0; bus.WE = '0; bus.LOCK = '0;
    bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;

    tbl[0] = '{1'b1, 1'b1, 5'd0,  8'h5A, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 5'd31, 8'hC3, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h5A};
    tbl[3] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'hC3};
    tbl[4] = '{1'b0, 1'b1, 5'd17, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 5'd17, 8'hFF, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 5'd17, 8'h00, 8'hFF};
    tbl[7] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h5A};

    // reset values
    do_reset();
    chk("rst_gnt", bus.GNT, 2'b00);
    chk("rst_ack", bus.ACK, 2'b00);
    chk("rst_cs_n", bus.RAM_CS_, 1'b1);
    chk("rst_oe_we", {bus.RAM_OE, bus.RAM_WE}, 2'b00);
    chk("rst_addr", bus.RAM_ADDR, 5'd0);
    chk("rst_wdata", bus.RAM_WDATA, 8'h00);
    chk("rst_rdata", {bus.RDATA0, bus.RDATA1}, 16'h0000);

    // CPU read of a preloaded word
    preload(5'd5, 8'hA5);
    run_xact("cpu_rd5", 1'b0, 1'b0, 5'd5, 8'h00, 8'hA5);

    // isolated transactions, including both address extremes
    for (int i = 0; i < 8; i++)
      run_xact($sformatf("tbl%0d", i), tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

    // DMA write then read-back
    run_xact("dma_wr17", 1'b1, 1'b1, 5'd17, 8'h3C, 8'h00);
    run_xact("dma_rd17", 1'b1, 1'b0, 5'd17, 8'h00, 8'h3C);

    // simultaneous requests after reset alternate CPU, DMA, CPU, DMA
    begin
      int nack, ack_t [4];
      logic [1:0] ack_p [4];
      bit both;
      nack = 0; both = 1'b0;
      for (int k = 0; k < 4; k++) begin ack_t[k] = -1; ack_p[k] = 'x; end
      do_reset();
      set_port(1'b0, 1'b0, 5'd5, 8'h00);
      set_port(1'b1, 1'b0, 5'd17, 8'h00);
      bus.REQ = 2'b11;
      for (int c = 1; c <= 16; c++) begin
        @(negedge CLK);
        if (bus.GNT == 2'b11) both = 1'b1;
        if (bus.ACK != 2'b00 && nack < 4) begin
          ack_t[nack] = c; ack_p[nack] = bus.ACK; nack++;
          if (nack == 4) bus.REQ = 2'b00;
        end
      end
      bus.REQ = 2'b00;
      chk("rr_nack", nack, 4);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_port%0d", k), ack_p[k], (k % 2) ? 2'b10 : 2'b01);
        chk($sformatf("rr_time%0d", k), ack_t[k], 3 + 3 * k);
      end
      chk("rr_gnt_both", both, 1'b0);
      chk("rr_rdata0", bus.RDATA0, 8'hA5);
      chk("rr_rdata1", bus.RDATA1, 8'h3C);
    end

    // fields and REQ changed after grant are ignored
    @(negedge CLK);
    set_port(1'b0, 1'b0, 5'd31, 8'h00);
    bus.REQ = 2'b01;
    @(negedge CLK);
    chk("mid_gnt", bus.GNT, 2'b01);
    chk("mid_setup_addr", bus.RAM_ADDR, 5'd31);
    bus.ADDR0 = 5'd17; bus.REQ = 2'b00;
    @(negedge CLK);
    chk("mid_acc_addr", bus.RAM_ADDR, 5'd31);
    chk("mid_oe", bus.RAM_OE, 1'b1);
    @(negedge CLK);
    chk("mid_ack", bus.ACK, 2'b01);
    chk("mid_rdata", bus.RDATA0, 8'hC3);

    // reset in the ACCESS cycle of a read
    begin
      int acks;
      acks = 0;
      @(negedge CLK);
      set_port(1'b0, 1'b0, 5'd5, 8'h00);
      bus.REQ = 2'b01;
      repeat (2) @(negedge CLK);
      chk("rstmid_in_access", bus.RAM_OE, 1'b1);
      RST_ = 1'b0;
      #1;
      chk("rstmid_gnt", bus.GNT, 2'b00);
      chk("rstmid_cs_n", bus.RAM_CS_, 1'b1);
      chk("rstmid_oe", bus.RAM_OE, 1'b0);
      chk("rstmid_rdata0", bus.RDATA0, 8'h00);
      bus.REQ = 2'b00;
      @(negedge CLK);
      RST_ = 1'b1;
      repeat (6) begin
        @(negedge CLK);
        if (bus.ACK != 2'b00) acks++;
      end
      chk("rstmid_no_ack", acks, 0);
    end

    // LOCK: regrant when enabled, ignored otherwise
    begin
      int ng;
      logic [1:0] g [4], exp_g [4];
`ifdef RAM_ARB_LOCK_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      ng = 0; gnt_prev = '0; ack_prev = '0;
      for (int k = 0; k < 4; k++) g[k] = 'x;
      do_reset();
      set_port(1'b0, 1'b0, 5'd5, 8'h00);
      set_port(1'b1, 1'b0, 5'd17, 8'h00);
      bus.LOCK = 2'b01;
      bus.REQ  = 2'b11;
      for (int c = 0; c < 24 && ng < 4; c++) begin
        @(negedge CLK);
        if (bus.GNT != 2'b00 && (gnt_prev == 2'b00 || ack_prev != 2'b00)) begin
          g[ng] = bus.GNT; ng++;
          if (ng == 3) bus.LOCK = 2'b00;
        end
        gnt_prev = bus.GNT; ack_prev = bus.ACK;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("lock_gnt%0d", k), g[k], exp_g[k]);
      repeat (4) @(negedge CLK);
      bus.REQ = 2'b00; bus.LOCK = 2'b00;
    end

    // randomized traffic against the transaction-level model
    do_reset();
    @(negedge CLK);
    pre_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      pre_addr = 5'(a); pre_data = 8'($urandom); sh[a] = pre_data;
      @(negedge CLK);
    end
    pre_en = 1'b0;
    gnt_prev = '0; ack_prev = '0; last_m = 1'b1; req_drv = '0;
    for (int p = 0; p < 2; p++) begin out_v[p] = 1'b0; out_t[p] = 0; end
    for (int c = 0; c < 2030; c++) begin
      @(negedge CLK);
      chk("rnd_exclusive", ($countones(bus.GNT) > 1) || ($countones(bus.ACK) > 1) ||
                           (bus.RAM_OE && bus.RAM_WE), 1'b0);
      if (bus.GNT != 2'b00 && (gnt_prev == 2'b00 || ack_prev != 2'b00)) begin
        pend  = req_drv & ~ack_prev;
        exp_w = (pend == 2'b11) ? ~last_m : pend[1];
        chk("rnd_pending", pend != 2'b00, 1'b1);
        chk("rnd_winner", bus.GNT, exp_w ? 2'b10 : 2'b01);
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.ACK[p]) begin
          chk("rnd_ack_owner", out_v[p], 1'b1);
          chk("rnd_latency", (c - out_t[p]) <= 10, 1'b1);
          if (!out_we[p]) chk("rnd_rdata", (p == 1) ? bus.RDATA1 : bus.RDATA0, sh[out_a[p]]);
          else            sh[out_a[p]] = out_d[p];
          last_m   = (p == 1);
          out_v[p] = 1'b0;
        end else if (out_v[p] && (c - out_t[p]) > 20) begin
          n_cmp++; n_err++;
          $display("FAIL rnd_hang: port %0d waited %0d cycles, want <= 10", p, c - out_t[p]);
          out_v[p] = 1'b0;
        end
      end
      gnt_prev = bus.GNT; ack_prev = bus.ACK;
      for (int p = 0; p < 2; p++) begin
        if (!out_v[p] && c < 2000 && $urandom_range(3) == 0) begin
          out_v[p]  = 1'b1;
          out_we[p] = 1'($urandom_range(1));
          out_a[p]  = 5'($urandom_range(31));
          out_d[p]  = 8'($urandom);
          out_t[p]  = c;
          set_port(1'(p), out_we[p], out_a[p], out_d[p]);
        end
      end
      req_drv = {out_v[1], out_v[0]};
      bus.REQ = req_drv;
    end
    chk("rnd_drained", {out_v[1], out_v[0]}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
